// File: rtl/pipe_elastic_chain.sv
// Elastic chain of DEPTH payload registers with valid/ready backpressure,
// bubble collapse, per-stage kill and saturating stall/kill statistics.
module pipe_elastic_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    input  logic [DEPTH-1:0]           kill,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           kill_cnt
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int SUM_W = CNT_W + 5;

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_next;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] src_valid;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] data      [DEPTH];
    logic [WIDTH-1:0] data_next [DEPTH];
    logic [WIDTH-1:0] src_data  [DEPTH];
    logic [OCC_W-1:0] occ_next;
    logic [4:0]       kill_hits;
    logic [SUM_W-1:0] kill_sum;
    logic [CNT_W-1:0] kill_next;
    logic [CNT_W-1:0] stall_next;
    logic             stall_now;

    assign live = v & ~kill;

    // A stage is ready when it is empty/killed or everything below it moves.
    always_comb begin : ready_chain
        logic r;
        r          = out_ready;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r      = !live[i] || r;
            rdy[i] = r;
        end
    end

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = live[i-1];
            src_data[i]  = data[i-1];
        end
    end

    // Refill wins over drain, so a killed stage can take its upstream entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            v_next[i]    = v[i];
            data_next[i] = data[i];
            if (src_valid[i] && rdy[i]) begin
                v_next[i]    = 1'b1;
                data_next[i] = src_data[i];
            end else if ((live[i] && rdy[i+1]) || kill[i]) begin
                v_next[i] = 1'b0;
            end
        end
    end

    always_comb begin
        occ_next  = '0;
        kill_hits = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_next  = occ_next + OCC_W'(v_next[i]);
            kill_hits = kill_hits + 5'(v[i] & kill[i]);
        end
        kill_sum   = SUM_W'(kill_cnt) + SUM_W'(kill_hits);
        kill_next  = (kill_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
        stall_now  = live[DEPTH-1] && !out_ready;
        stall_next = (stall_now && (stall_cnt != {CNT_W{1'b1}})) ? stall_cnt + CNT_W'(1) : stall_cnt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v         <= '0;
            occupancy <= '0;
            stall_cnt <= '0;
            kill_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else begin
            v         <= v_next;
            occupancy <= occ_next;
            stall_cnt <= stall_next;
            kill_cnt  <= kill_next;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= data_next[i];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = live[DEPTH-1];
    assign out_data  = data[DEPTH-1];

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Directed and randomized bench for pipe_elastic_chain, checked against a
// slot model that moves entries whenever a hole exists further downstream.
module tb_pipe_elastic_chain;

    localparam int W    = 16;
    localparam int D    = 4;
    localparam int C    = 4;
    localparam int CMAX = (1 << C) - 1;

    logic           clock;
    logic           reset;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [D-1:0]   kill;
    logic [2:0]     occupancy;
    logic [C-1:0]   stall_cnt;
    logic [C-1:0]   kill_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cycleNo     = 0;

    bit           mv [D];
    logic [W-1:0] md [D];
    int           mOcc;
    int           mStall;
    int           mKill;

    logic [W-1:0] got    [$];
    int           gotCyc [$];
    logic [W-1:0] expQ   [$];

    pipe_elastic_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .kill     (kill),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt),
        .kill_cnt (kill_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleNo);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < D; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
        mOcc   = 0;
        mStall = 0;
        mKill  = 0;
    endtask

    // One clock: drive inputs, compare against the model, then advance the model.
    task automatic applyStimulus(input bit rst, input bit iv, input logic [W-1:0] id,
                                 input bit ordy, input logic [D-1:0] k);
        bit           mlive   [D];
        bit           canMove [D+1];
        bit           nv      [D];
        logic [W-1:0] nd      [D];
        int           nLive;
        int           hits;
        @(negedge clock);
        reset     = rst;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        kill      = k;
        #1;
        for (int i = 0; i < D; i++) mlive[i] = mv[i] && !k[i];
        for (int i = 0; i <= D; i++) begin
            nLive = 0;
            for (int j = i; j < D; j++) nLive += int'(mlive[j]);
            canMove[i] = ordy || (nLive < D - i);
        end
        checkOutput("in_ready", 32'(in_ready), 32'(canMove[0]));
        checkOutput("out_valid", 32'(out_valid), 32'(mlive[D-1]));
        if (mlive[D-1]) checkOutput("out_data", 32'(out_data), 32'(md[D-1]));
        checkOutput("occupancy", 32'(occupancy), 32'(mOcc));
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(mStall));
        checkOutput("kill_cnt", 32'(kill_cnt), 32'(mKill));
        if (!rst && out_valid && ordy) begin
            got.push_back(out_data);
            gotCyc.push_back(cycleNo);
        end
        if (rst) begin
            modelClear();
        end else begin
            hits = 0;
            for (int i = 0; i < D; i++) begin
                nv[i] = 1'b0;
                nd[i] = md[i];
                if (mv[i] && k[i]) hits++;
            end
            for (int i = D - 1; i >= 0; i--) begin
                if (mlive[i]) begin
                    if (canMove[i+1]) begin
                        if (i + 1 < D) begin
                            nv[i+1] = 1'b1;
                            nd[i+1] = md[i];
                        end
                    end else begin
                        nv[i] = 1'b1;
                    end
                end
            end
            if (iv && canMove[0]) begin
                nv[0] = 1'b1;
                nd[0] = id;
            end
            if (mlive[D-1] && !ordy && mStall < CMAX) mStall++;
            mKill = (mKill + hits > CMAX) ? CMAX : mKill + hits;
            mOcc  = 0;
            for (int i = 0; i < D; i++) begin
                mv[i] = nv[i];
                md[i] = nd[i];
                mOcc += int'(nv[i]);
            end
        end
        cycleNo++;
    endtask

    task automatic checkGot(input string tag);
        checkOutput({tag, "_count"}, 32'(got.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < got.size(); i++)
            checkOutput(tag, 32'(got[i]), 32'(expQ[i]));
    endtask

    task automatic resetAll();
        applyStimulus(1'b1, 1'b0, '0, 1'b1, '0);
        got.delete();
        gotCyc.delete();
    endtask

    initial begin
        int firstV;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        kill      = '0;
        repeat (2) @(posedge clock);
        modelClear();

        // Streaming
        resetAll();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        firstV = -1;
        for (int n = 0; n < 14; n++) begin
            applyStimulus(1'b0, n < 8, W'(16'h10 + n), 1'b1, '0);
            if (out_valid && firstV < 0) firstV = n;
            if (n == 6) checkOutput("stream_occ", 32'(occupancy), 32'd4);
        end
        checkOutput("stream_first_valid", 32'(firstV), 32'd4);
        expQ = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h14, 16'h15, 16'h16, 16'h17};
        checkGot("stream_seq");
        if (gotCyc.size() == 8) checkOutput("stream_gapless", 32'(gotCyc[7] - gotCyc[0]), 32'd7);
        checkOutput("stream_stall", 32'(stall_cnt), 32'd0);

        // Full and backpressure
        resetAll();
        for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b1, W'(16'hA0 + n), 1'b0, '0);
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b0, 1'b1, 16'hEE, 1'b0, '0);
            checkOutput("full_in_ready", 32'(in_ready), 32'd0);
            checkOutput("full_hold", 32'(out_data), 32'hA0);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1, '0);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("full_stall", 32'(stall_cnt), 32'd5);
        for (int n = 0; n < 5; n++) applyStimulus(1'b0, 1'b0, '0, 1'b1, '0);
        expQ = '{16'hA0, 16'hA1, 16'hA2, 16'hA3};
        checkGot("full_seq");

        // Bubble collapse
        resetAll();
        for (int n = 0; n < 8; n++)
            applyStimulus(1'b0, n == 0 || n == 3, (n == 0) ? 16'h1 : 16'h2, 1'b0, '0);
        checkOutput("bubble_occ", 32'(occupancy), 32'd2);
        for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b0, '0, 1'b1, '0);
        expQ = '{16'h1, 16'h2};
        checkGot("bubble_seq");
        if (gotCyc.size() == 2) checkOutput("bubble_back2back", 32'(gotCyc[1] - gotCyc[0]), 32'd1);

        // Kill of two middle stages
        resetAll();
        for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b1, W'(16'hB0 + n), 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 4'b0110);
        for (int n = 0; n < 6; n++) applyStimulus(1'b0, 1'b0, '0, 1'b1, '0);
        expQ = '{16'hB0, 16'hB3};
        checkGot("kill_seq");
        checkOutput("kill_cnt2", 32'(kill_cnt), 32'd2);

        // Kill and refill at stage 0
        resetAll();
        for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b1, W'(16'hD0 + n), 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 16'hC0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 16'hC1, 1'b0, 4'b0001);
        checkOutput("refill_in_ready", 32'(in_ready), 32'd1);
        for (int n = 0; n < 6; n++) applyStimulus(1'b0, 1'b0, '0, 1'b1, '0);
        expQ = '{16'hD0, 16'hD1, 16'hD2, 16'hC1};
        checkGot("refill_seq");
        checkOutput("refill_kill_cnt", 32'(kill_cnt), 32'd1);

        // Mid-stream reset, then stall counter saturation
        resetAll();
        for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b1, W'(16'hE0 + n), 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
        checkOutput("midrst_occ", 32'(occupancy), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 1'b1, 16'h5, 1'b0, '0);
        for (int n = 0; n < 29; n++) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
        checkOutput("stall_sat", 32'(stall_cnt), 32'd15);

        // Randomized traffic against the model
        resetAll();
        for (int n = 0; n < 2000; n++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 3) != 0,
                          W'($urandom),
                          $urandom_range(0, 2) != 0,
                          ($urandom_range(0, 7) == 0) ? D'($urandom) : '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
